// File: rtl/fifo_shift_ram_reader_if.sv
// rtl/fifo_shift_ram_reader_if.sv - read request/response and RAM read-port bundle for the shift FIFO reader
interface fifo_shift_ram_reader_if #(
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [3:0]        rd_sel;
    logic              rd_busy;
    logic              rd_err;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              ram_re;
    logic [10:0]       addrb;
    logic [DATA_W-1:0] ram_dout;

    // Consumer side plus RAM model: issues requests, supplies read data
    modport master (
        output rd_req, rd_sel, ram_dout,
        input  rd_busy, rd_err, rd_valid, rd_data, ram_re, addrb
    );

    // Reader side: accepts requests, drives the RAM read port
    modport slave (
        input  rd_req, rd_sel, ram_dout,
        output rd_busy, rd_err, rd_valid, rd_data, ram_re, addrb
    );
endinterface

// File: rtl/fifo_shift_ram_reader.sv
// rtl/fifo_shift_ram_reader.sv - per-level occupancy/pointer tracking and single-word read sequencing
module fifo_shift_ram_reader #(
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            push,
    output logic                   ovf_err,
    output logic [120:0]           raddr,
    fifo_shift_ram_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  sel;
    logic [10:0] rp  [11];
    logic [7:0]  cnt [11];
    logic        req_ok;
    logic [10:0] req_rp;

    // Level base addresses are irregular, so they are tabulated
    function automatic logic [10:0] lvl_base(input int k);
        case (k)
            0:       return 11'd0;
            1:       return 11'd64;
            2:       return 11'd128;
            3:       return 11'd256;
            4:       return 11'd384;
            5:       return 11'd512;
            6:       return 11'd640;
            7:       return 11'd768;
            8:       return 11'd1024;
            9:       return 11'd1280;
            default: return 11'd1536;
        endcase
    endfunction

    function automatic logic [7:0] lvl_depth(input int k);
        return 8'(17 * (k + 1));
    endfunction

    function automatic logic [10:0] lvl_top(input int k);
        return lvl_base(k) + 11'(lvl_depth(k)) - 11'd1;
    endfunction

    // Look up the requested level without indexing past level 10
    always_comb begin
        req_ok = 1'b0;
        req_rp = '0;
        for (int k = 0; k < 11; k++) begin
            if (bus.rd_sel == 4'(k)) begin
                req_ok = (cnt[k] != 8'd0);
                req_rp = rp[k];
            end
        end
    end

    // Expose every level's read pointer as one packed vector
    always_comb begin
        raddr = '0;
        for (int k = 0; k < 11; k++) begin
            raddr[11*k +: 11] = rp[k];
        end
    end

    // Read sequencer plus per-level pointer/count bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= '0;
            bus.ram_re   <= 1'b0;
            bus.addrb    <= '0;
            bus.rd_busy  <= 1'b0;
            bus.rd_err   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            ovf_err      <= 1'b0;
            for (int k = 0; k < 11; k++) begin
                rp[k]  <= lvl_base(k);
                cnt[k] <= 8'd0;
            end
        end else begin
            bus.rd_err   <= 1'b0;
            bus.rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_req) begin
                        if (req_ok) begin
                            sel         <= bus.rd_sel;
                            bus.ram_re  <= 1'b1;
                            bus.addrb   <= req_rp;
                            bus.rd_busy <= 1'b1;
                            state       <= READ;
                        end else begin
                            bus.rd_err  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    bus.ram_re <= 1'b0;
                    bus.addrb  <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    bus.rd_data  <= bus.ram_dout;
                    bus.rd_valid <= 1'b1;
                    state        <= DONE;
                end
                default: begin
                    bus.rd_busy <= 1'b0;
                    state       <= IDLE;
                end
            endcase

            // A push and a read on the same level cancel; a push into a full level is dropped and flagged
            for (int k = 0; k < 11; k++) begin
                logic dec;
                dec = (state == READ) && (sel == 4'(k));
                if (dec) begin
                    rp[k] <= (rp[k] == lvl_top(k)) ? lvl_base(k) : rp[k] + 11'd1;
                end
                case ({push[k], dec})
                    2'b10: begin
                        if (cnt[k] == lvl_depth(k)) ovf_err <= 1'b1;
                        else                        cnt[k]  <= cnt[k] + 8'd1;
                    end
                    2'b01:   cnt[k] <= cnt[k] - 8'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_shift_ram_reader.sv
// tb/tb_fifo_shift_ram_reader.sv - randomized self-checking bench for fifo_shift_ram_reader
module tb_fifo_shift_ram_reader;
    logic         clk = 1'b0;
    logic         reset;
    logic [10:0]  push;
    logic         ovf_err;
    logic [120:0] raddr;

    fifo_shift_ram_reader_if #(.DATA_W(16)) bus ();

    fifo_shift_ram_reader #(.DATA_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .ovf_err (ovf_err),
        .raddr   (raddr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2048];
    always @(posedge clk) if (bus.ram_re) bus.ram_dout <= mem[bus.addrb];

    int base_tab [11] = '{0, 64, 128, 256, 384, 512, 640, 768, 1024, 1280, 1536};
    int m_cnt [11];
    int m_rd  [11];
    bit m_ovf;
    int n_cmp = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int depth(input int k);
        return 17 * (k + 1);
    endfunction

    function automatic int exp_addr(input int k);
        return base_tab[k] + (m_rd[k] % depth(k));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 11; k++) begin
            m_cnt[k] = 0;
            m_rd[k]  = 0;
        end
        m_ovf = 0;
    endtask

    task automatic do_push(input logic [10:0] mask);
        push = mask;
        tick();
        push = '0;
        for (int k = 0; k < 11; k++) begin
            if (mask[k]) begin
                if (m_cnt[k] == depth(k)) m_ovf = 1;
                else                      m_cnt[k]++;
            end
        end
    endtask

    // Issues one request and reports what the DUT did; callers judge the result
    task automatic do_read(input int sel, output logic err, output int addr,
                           output logic [15:0] data, output int re_at, output int vld_at);
        err = 0; addr = -1; data = '0; re_at = -1; vld_at = -1;
        bus.rd_req = 1'b1;
        bus.rd_sel = 4'(sel);
        tick();
        bus.rd_req = 1'b0;
        err = bus.rd_err;
        for (int i = 1; i <= 5; i++) begin
            if (bus.ram_re && re_at < 0) begin
                re_at = i;
                addr  = int'(bus.addrb);
            end
            if (bus.rd_valid && vld_at < 0) begin
                vld_at = i;
                data   = bus.rd_data;
            end
            if (vld_at >= 0 || (err && i == 2)) break;
            tick();
        end
        tick();
    endtask

    // Reads one word and compares it with the model's expectation
    task automatic read_check(input string name, input int sel);
        logic err; int addr; logic [15:0] data; int re_at; int vld_at;
        logic exp_err;
        int ea;
        exp_err = (sel > 10) || (m_cnt[sel] == 0);
        ea = exp_err ? -1 : exp_addr(sel);
        do_read(sel, err, addr, data, re_at, vld_at);
        n_cmp++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s rd_err sel=%0d got=%0b exp=%0b", name, sel, err, exp_err);
        end else if (exp_err) begin
            n_cmp++;
            if (re_at != -1) begin
                n_fail++;
                $display("FAIL %s ram_re on reject got_cycle=%0d exp=none", name, re_at);
            end
        end else begin
            n_cmp++;
            if (addr != ea || vld_at - re_at != 2 || data !== mem[ea]) begin
                n_fail++;
                $display("FAIL %s read sel=%0d addrb got=%0d exp=%0d lat got=%0d exp=2 data got=%h exp=%h",
                         name, sel, addr, ea, vld_at - re_at, data, mem[ea]);
            end
            m_rd[sel]++;
            m_cnt[sel]--;
        end
    endtask

    task automatic check_raddr(input string name);
        for (int k = 0; k < 11; k++) begin
            n_cmp++;
            if (int'(raddr[11*k +: 11]) != exp_addr(k)) begin
                n_fail++;
                $display("FAIL %s raddr[%0d] got=%0d exp=%0d", name, k, raddr[11*k +: 11], exp_addr(k));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; push = '0; bus.rd_req = 1'b0; bus.rd_sel = '0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if ({bus.ram_re, bus.addrb, bus.rd_busy, bus.rd_err, bus.rd_valid, bus.rd_data, ovf_err} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got re=%b addrb=%0d busy=%b err=%b vld=%b data=%h ovf=%b exp all 0",
                     bus.ram_re, bus.addrb, bus.rd_busy, bus.rd_err, bus.rd_valid, bus.rd_data, ovf_err);
        end
        check_raddr("reset");
    endtask

    task automatic test_reject_empty();
        read_check("reject_empty", 0);
    endtask

    task automatic test_level2();
        logic err; int addr; logic [15:0] data; int re_at; int vld_at;
        int want [3] = '{128, 129, 130};
        for (int i = 0; i < 3; i++) do_push(11'b1 << 2);
        for (int i = 0; i < 3; i++) begin
            do_read(2, err, addr, data, re_at, vld_at);
            n_cmp++;
            if (err !== 1'b0 || addr != want[i] || vld_at - re_at != 2 || data !== mem[want[i]]) begin
                n_fail++;
                $display("FAIL level2 read%0d err=%b addrb got=%0d exp=%0d lat got=%0d exp=2 data got=%h exp=%h",
                         i, err, addr, want[i], vld_at - re_at, data, mem[want[i]]);
            end
            m_rd[2]++;
            m_cnt[2]--;
        end
        read_check("level2_fourth", 2);
    endtask

    task automatic test_wrap_level0();
        for (int i = 0; i < 17; i++) do_push(11'b1);
        for (int i = 0; i < 17; i++) read_check("wrap_fill", 0);
        do_push(11'b1);
        n_cmp++;
        if (exp_addr(0) != 0) begin
            n_fail++;
            $display("FAIL wrap model addr got=%0d exp=0", exp_addr(0));
        end
        read_check("wrap_after", 0);
        check_raddr("wrap");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) do_push(11'b1);
        n_cmp++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow ovf_err got=%b exp=1", ovf_err);
        end
        for (int i = 0; i < 18; i++) read_check("overflow_drain", 0);
        n_cmp++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky ovf_err got=%b exp=1", ovf_err);
        end
    endtask

    task automatic test_push_during_read();
        do_push(11'b1 << 10);
        bus.rd_req = 1'b1; bus.rd_sel = 4'd10;
        tick();
        bus.rd_req = 1'b0;
        n_cmp++;
        if (bus.ram_re !== 1'b1 || bus.addrb !== 11'd1536) begin
            n_fail++;
            $display("FAIL push_read first re=%b addrb=%0d exp re=1 addrb=1536", bus.ram_re, bus.addrb);
        end
        push = 11'b1 << 10;
        tick();
        push = '0;
        tick();
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== mem[1536]) begin
            n_fail++;
            $display("FAIL push_read data vld=%b got=%h exp=%h", bus.rd_valid, bus.rd_data, mem[1536]);
        end
        tick();
        m_rd[10]++;
        read_check("push_read_second", 10);
        read_check("push_read_empty", 10);
    endtask

    task automatic test_back_to_back();
        int pulses [$];
        read_check("bad_sel", 11);
        for (int i = 0; i < 3; i++) do_push(11'b1 << 5);
        bus.rd_req = 1'b1; bus.rd_sel = 4'd5;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.ram_re) pulses.push_back(i);
        end
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        m_rd[5] += 3;
        m_cnt[5] = 0;
        n_cmp++;
        if (pulses.size() != 3) begin
            n_fail++;
            $display("FAIL back_to_back pulse_count got=%0d exp=3", pulses.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (pulses[i] - pulses[i-1] != 4) begin
                    n_fail++;
                    $display("FAIL back_to_back gap%0d got=%0d exp=4", i, pulses[i] - pulses[i-1]);
                end
            end
        end
        check_raddr("back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) do_push(11'($urandom));
            else                           read_check("random_read", int'($urandom_range(0, 12)));
        end
        n_cmp++;
        if (ovf_err !== m_ovf) begin
            n_fail++;
            $display("FAIL random ovf_err got=%b exp=%b", ovf_err, m_ovf);
        end
        check_raddr("random");
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        do_push(11'b1 << 3);
        bus.rd_req = 1'b1; bus.rd_sel = 4'd3;
        tick();
        bus.rd_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.rd_busy !== 1'b0 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait vld=%b busy=%b ovf=%b exp 0 0 0", bus.rd_valid, bus.rd_busy, ovf_err);
        end
        check_raddr("reset_wait");
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rd_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait late rd_valid got=1 exp=0");
        end
        read_check("reset_wait_empty", 3);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        test_reset();
        test_reject_empty();
        test_level2();
        test_wrap_level0();
        test_overflow();
        test_push_during_read();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
